// File: rtl/cache_ctrl_fsm.sv
// Request-side controller for a 4-way, 128-set tag array: one CPU request at a time,
// tag lookup, tree-PLRU victim choice, and write-through / read-allocate memory handshake.
module cache_ctrl_fsm #(
  parameter int ADDR_BITS   = 32,
  parameter int TAG_BITS    = 19,
  parameter int INDEX_BITS  = 7,
  parameter int OFFSET_BITS = 6,
  parameter int NUM_SETS    = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_BITS-1:0]  cpu_req_addr,
  input  logic                  cpu_req_we,
  output logic                  cpu_resp_valid,
  output logic                  cpu_resp_hit,
  output logic [1:0]            cpu_resp_way,
  output logic [INDEX_BITS-1:0] ta_set_index,
  output logic [TAG_BITS-1:0]   ta_tag,
  output logic                  ta_read,
  output logic                  ta_write_enable,
  output logic [1:0]            ta_update_way,
  input  logic                  ta_hit,
  input  logic [1:0]            ta_way,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_BITS-1:0]  mem_req_addr,
  input  logic                  mem_resp_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT, S_FILL, S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   we_q, we_d;
  logic                   hit_q, hit_d;
  logic [1:0]             way_q, way_d;
  logic                   run_q;
  logic [2:0]             plru_q [NUM_SETS];
  logic                   plru_we;
  logic [2:0]             plru_wdata;
  logic [2:0]             plru_cur;

  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    return b[0] ? (b[2] ? 2'd3 : 2'd2) : (b[1] ? 2'd1 : 2'd0);
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] r;
    r    = b;
    r[0] = ~w[1];
    if (!w[1]) r[1] = ~w[0];
    else       r[2] = ~w[0];
    return r;
  endfunction

  assign ta_set_index = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign ta_tag       = addr_q[ADDR_BITS-1 -: TAG_BITS];
  assign plru_cur     = plru_q[ta_set_index];

  // way_q doubles as the latched victim on a read miss, so FILL and RESP share it
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    we_d            = we_q;
    hit_d           = hit_q;
    way_d           = way_q;
    plru_we         = 1'b0;
    plru_wdata      = plru_cur;
    cpu_req_ready   = 1'b0;
    cpu_resp_valid  = 1'b0;
    cpu_resp_hit    = 1'b0;
    cpu_resp_way    = 2'd0;
    ta_read         = 1'b0;
    ta_write_enable = 1'b0;
    ta_update_way   = 2'd0;
    mem_req_valid   = 1'b0;
    mem_req_we      = 1'b0;
    mem_req_addr    = '0;
    case (state_q)
      S_IDLE: begin
        cpu_req_ready = run_q;
        if (cpu_req_valid && run_q) begin
          addr_d  = cpu_req_addr;
          we_d    = cpu_req_we;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        ta_read = 1'b1;
        hit_d   = ta_hit;
        way_d   = ta_hit ? ta_way : (we_q ? 2'd0 : plru_victim(plru_cur));
        if (ta_hit) begin
          plru_we    = 1'b1;
          plru_wdata = plru_touch(plru_cur, ta_way);
        end
        state_d = (ta_hit && !we_q) ? S_RESP : S_MEM_REQ;
      end
      S_MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = we_q;
        mem_req_addr  = we_q ? addr_q
                             : {addr_q[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        if (mem_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_resp_valid) state_d = we_q ? S_RESP : S_FILL;
      end
      S_FILL: begin
        ta_write_enable = 1'b1;
        ta_update_way   = way_q;
        plru_we         = 1'b1;
        plru_wdata      = plru_touch(plru_cur, way_q);
        state_d         = S_RESP;
      end
      S_RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_hit   = hit_q;
        cpu_resp_way   = way_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // run_q holds ready low during reset and for the release cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      way_q   <= 2'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
      way_q   <= way_d;
      run_q   <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_plru
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        plru_q[gi] <= 3'b000;
      else if (plru_we && ta_set_index == INDEX_BITS'(gi))
        plru_q[gi] <= plru_wdata;
    end
  end

endmodule
